// File: rtl/bus_slot_arbiter_pkg.sv
// Shared encodings for the SRAM bus slot arbiter: slot owners and MCU handshake states.
package bus_slot_arbiter_pkg;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_VIDEO = 2'd0;
  localparam slot_t SLOT_CPU   = 2'd1;
  localparam slot_t SLOT_MCU   = 2'd2;

  typedef logic [1:0] mcu_state_t;

  localparam mcu_state_t MCU_IDLE    = 2'd0;
  localparam mcu_state_t MCU_PENDING = 2'd1;
  localparam mcu_state_t MCU_ACTIVE  = 2'd2;
  localparam mcu_state_t MCU_DONE    = 2'd3;

  function automatic slot_t next_slot(input slot_t s);
    case (s)
      SLOT_VIDEO: return SLOT_CPU;
      SLOT_CPU:   return SLOT_MCU;
      default:    return SLOT_VIDEO;
    endcase
  endfunction

endpackage

// File: rtl/bus_slot_arbiter_mcu_req_fsm.sv
// MCU (SPI bridge) request path: 2-flop synchronizer on mcu_pending plus the
// pending/active/done handshake that claims one eligible slot per request.
module bus_slot_arbiter_mcu_req_fsm
  import bus_slot_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mcu_pending,
  input  logic mcu_we,
  input  logic slot_start,
  input  logic slot_end,
  input  logic eligible,
  output logic grant,
  output logic strobe,
  output logic done,
  output logic we_eff
);

  logic       sync1;
  logic       pend_s;
  logic       we_l;
  mcu_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      pend_s <= 1'b0;
      state  <= MCU_IDLE;
      we_l   <= 1'b0;
    end else begin
      sync1  <= mcu_pending;
      pend_s <= sync1;
      if (!pend_s) begin
        state <= MCU_IDLE;
      end else begin
        case (state)
          MCU_IDLE:    state <= MCU_PENDING;
          MCU_PENDING: begin
            if (slot_start && eligible) begin
              state <= MCU_ACTIVE;
              we_l  <= mcu_we;
            end
          end
          MCU_ACTIVE:  if (slot_end) state <= MCU_DONE;
          MCU_DONE:    state <= MCU_DONE;
          default:     state <= MCU_IDLE;
        endcase
      end
    end
  end

  // The grant is raised combinationally in the slot-start cycle so the MCU owns the
  // whole slot; a synchronized drop of pending pulls it (and the strobe) immediately.
  always_comb begin
    grant  = pend_s && ((state == MCU_ACTIVE) ||
                        ((state == MCU_PENDING) && slot_start && eligible));
    strobe = pend_s && (state == MCU_ACTIVE) && slot_end;
    done   = (state == MCU_DONE);
    we_eff = (state == MCU_ACTIVE) ? we_l : mcu_we;
  end

endmodule

// File: rtl/bus_slot_arbiter.sv
// Time-division SRAM bus arbiter: VIDEO/CPU/MCU slot frame, RAM control decode,
// per-owner strobes and the MCU pending/done handshake.
module bus_slot_arbiter
  import bus_slot_arbiter_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 4
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_we,
  input  logic       cpu_halt,
  input  logic       mcu_pending,
  input  logic       mcu_we,
  output logic [1:0] slot,
  output logic       mcu_grant,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       video_strobe,
  output logic       cpu_en,
  output logic       mcu_strobe,
  output logic       mcu_done
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] cnt;
  slot_t         slot_q;
  logic          cpu_halt_l;
  logic          cpu_we_l;

  logic slot_start;
  logic slot_end;
  logic mid;
  logic halt_eff;
  logic cpu_we_eff;
  logic eligible;

  logic fsm_grant;
  logic fsm_strobe;
  logic fsm_done;
  logic mcu_we_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      slot_q     <= SLOT_VIDEO;
      cpu_halt_l <= 1'b0;
      cpu_we_l   <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        slot_q <= next_slot(slot_q);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (slot_start && (slot_q == SLOT_CPU)) begin
        cpu_halt_l <= cpu_halt;
        cpu_we_l   <= cpu_we;
      end
    end
  end

  // CPU controls are sampled at slot start: live value on cnt==0, latched copy after.
  always_comb begin
    slot_start = (cnt == '0);
    slot_end   = (cnt == CNT_LAST);
    mid        = !slot_start && !slot_end;
    halt_eff   = slot_start ? cpu_halt : cpu_halt_l;
    cpu_we_eff = slot_start ? cpu_we   : cpu_we_l;
    eligible   = (slot_q == SLOT_MCU) || ((slot_q == SLOT_CPU) && halt_eff);
  end

  bus_slot_arbiter_mcu_req_fsm u_mcu_req_fsm (
    .clk         (clk),
    .reset       (reset),
    .mcu_pending (mcu_pending),
    .mcu_we      (mcu_we),
    .slot_start  (slot_start),
    .slot_end    (slot_end),
    .eligible    (eligible),
    .grant       (fsm_grant),
    .strobe      (fsm_strobe),
    .done        (fsm_done),
    .we_eff      (mcu_we_eff)
  );

  always_comb begin
    ram_oe       = 1'b0;
    ram_we       = 1'b0;
    video_strobe = 1'b0;
    cpu_en       = 1'b0;
    if (!reset) begin
      case (slot_q)
        SLOT_VIDEO: begin
          ram_oe       = 1'b1;
          video_strobe = slot_end;
        end
        SLOT_CPU: begin
          if (fsm_grant) begin
            ram_oe = !mcu_we_eff;
            ram_we = mcu_we_eff && mid;
          end else if (!halt_eff) begin
            ram_oe = !cpu_we_eff;
            ram_we = cpu_we_eff && mid;
            cpu_en = slot_end;
          end
        end
        SLOT_MCU: begin
          if (fsm_grant) begin
            ram_oe = !mcu_we_eff;
            ram_we = mcu_we_eff && mid;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    slot       = slot_q;
    mcu_grant  = fsm_grant  && !reset;
    mcu_strobe = fsm_strobe && !reset;
    mcu_done   = fsm_done   && !reset;
  end

  a_oe_we_excl: assert property (@(posedge clk) disable iff (reset) !(ram_oe && ram_we));
  a_we_window:  assert property (@(posedge clk) disable iff (reset)
                                 ram_we |-> (cnt != '0 && cnt != CNT_LAST));
  a_strobe_own: assert property (@(posedge clk) disable iff (reset) mcu_strobe |-> mcu_grant);

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Bench for bus_slot_arbiter: reset/idle vector table, hand-written MCU handshake
// sequences and a randomized run against a cycle-indexed reference model.
module tb_bus_slot_arbiter;

  localparam int unsigned SC = 4;
  localparam int NV = 38;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_we = 1'b0;
  logic       cpu_halt = 1'b0;
  logic       mcu_pending = 1'b0;
  logic       mcu_we = 1'b0;
  logic [1:0] slot;
  logic       mcu_grant, ram_oe, ram_we, video_strobe, cpu_en, mcu_strobe, mcu_done;

  always #5 clk = ~clk;

  bus_slot_arbiter #(.SLOT_CYCLES(SC)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_we       (cpu_we),
    .cpu_halt     (cpu_halt),
    .mcu_pending  (mcu_pending),
    .mcu_we       (mcu_we),
    .slot         (slot),
    .mcu_grant    (mcu_grant),
    .ram_oe       (ram_oe),
    .ram_we       (ram_we),
    .video_strobe (video_strobe),
    .cpu_en       (cpu_en),
    .mcu_strobe   (mcu_strobe),
    .mcu_done     (mcu_done)
  );

  typedef struct packed {
    logic [1:0] slot;
    logic grant, oe, we, vs, cen, ms, done;
  } outs_t;

  typedef struct packed {
    logic i_rst, i_cwe, i_halt, i_pend, i_mwe, ckslot;
    outs_t exp;
  } vec_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cur_n = 0;
  outs_t got;
  outs_t mexp;
  vec_t  tbl [NV];

  // Reference model: cycle index since reset release gives slot and phase directly;
  // the request is tracked as waiting / owning-a-slot / finished flags.
  int unsigned n = 0;
  bit hist[$];
  bit cap_halt = 1'b0, cap_we = 1'b0, m_we = 1'b0;
  bit waiting = 1'b0, owning = 1'b0, finished = 1'b0;

  task automatic model_step(input bit rst, input bit w, input bit h, input bit p, input bit mw);
    int unsigned c, s;
    bit ps, start, last, mid, elig, g;
    c = n % SC;
    s = (n / SC) % 3;
    start = (c == 0);
    last  = (c == SC - 1);
    mid   = !start && !last;
    ps    = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
    mexp = '0;
    mexp.slot = 2'(s);
    if (rst) begin
      n = 0;
      hist.delete();
      waiting = 0; owning = 0; finished = 0;
      return;
    end
    if (start && s == 1) begin
      cap_halt = h;
      cap_we   = w;
    end
    elig = start && (s == 2 || (s == 1 && cap_halt));
    g = owning && ps;
    if (waiting && ps && elig) begin
      g = 1'b1;
      m_we = mw;
    end
    mexp.grant = g;
    mexp.ms    = owning && ps && last;
    mexp.done  = finished;
    if (s == 0) begin
      mexp.oe = 1'b1;
    end else if (g) begin
      mexp.oe = !m_we;
      mexp.we = m_we && mid;
    end else if (s == 1 && !cap_halt) begin
      mexp.oe = !cap_we;
      mexp.we = cap_we && mid;
    end
    mexp.vs  = (s == 0) && last;
    mexp.cen = (s == 1) && last && !cap_halt;
    if (!ps) begin
      waiting = 0; owning = 0; finished = 0;
    end else if (owning && last) begin
      owning = 0; finished = 1;
    end else if (waiting && elig) begin
      waiting = 0; owning = 1;
    end else if (!waiting && !owning && !finished) begin
      waiting = 1;
    end
    hist.push_back(p);
    if (hist.size() > 4) void'(hist.pop_front());
    n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d: got %0d expected %0d", name, cur_n, act, exp);
    end
  endtask

  task automatic cmp_outs(input outs_t g, input outs_t e, input bit ckslot, input string tag);
    if (ckslot) chk({tag, "_slot"}, 32'(g.slot), 32'(e.slot));
    chk({tag, "_grant"},  32'(g.grant), 32'(e.grant));
    chk({tag, "_ram_oe"}, 32'(g.oe),    32'(e.oe));
    chk({tag, "_ram_we"}, 32'(g.we),    32'(e.we));
    chk({tag, "_vstrb"},  32'(g.vs),    32'(e.vs));
    chk({tag, "_cpu_en"}, 32'(g.cen),   32'(e.cen));
    chk({tag, "_mstrb"},  32'(g.ms),    32'(e.ms));
    chk({tag, "_done"},   32'(g.done),  32'(e.done));
  endtask

  task automatic cyc(input bit rst, input bit w, input bit h, input bit p, input bit mw);
    @(posedge clk);
    #1;
    reset = rst; cpu_we = w; cpu_halt = h; mcu_pending = p; mcu_we = mw;
    cur_n = n;
    model_step(rst, w, h, p, mw);
    @(negedge clk);
    got.slot = slot;      got.grant = mcu_grant; got.oe = ram_oe;  got.we = ram_we;
    got.vs = video_strobe; got.cen = cpu_en;     got.ms = mcu_strobe; got.done = mcu_done;
  endtask

  task automatic mstep(input bit rst, input bit w, input bit h, input bit p, input bit mw);
    outs_t e;
    cyc(rst, w, h, p, mw);
    e = mexp;
    cmp_outs(got, e, 1'b1, "model");
    chk("oe_we_excl", 32'(got.oe & got.we), 32'd0);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_grant, strobe_at, cen_seen, ms_seen, done_seen, done_cnt, we_cnt;
    logic [1:0] gslot;
    bit h, p, r;

    // Reset vectors, then 24 idle cycles and 12 cycles with cpu_we held high.
    tbl[0] = '0; tbl[0].i_rst = 1'b1;
    tbl[1] = '0; tbl[1].i_rst = 1'b1; tbl[1].ckslot = 1'b1;
    for (int i = 0; i < 36; i++) begin
      int unsigned c, s;
      bit w;
      c = i % SC;
      s = (i / SC) % 3;
      w = (i >= 24);
      tbl[i+2] = '0;
      tbl[i+2].i_cwe    = w;
      tbl[i+2].ckslot   = 1'b1;
      tbl[i+2].exp.slot = 2'(s);
      tbl[i+2].exp.oe   = (s == 0) || (s == 1 && !w);
      tbl[i+2].exp.we   = (s == 1) && w && (c == 1 || c == 2);
      tbl[i+2].exp.vs   = (s == 0) && (c == SC - 1);
      tbl[i+2].exp.cen  = (s == 1) && (c == SC - 1);
    end

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].i_rst, tbl[i].i_cwe, tbl[i].i_halt, tbl[i].i_pend, tbl[i].i_mwe);
      cmp_outs(got, tbl[i].exp, tbl[i].ckslot, "table");
    end

    // A: pending rises one clk before an MCU slot; synchronizer pushes grant a frame out.
    while (n < 43) mstep(0, 0, 0, 0, 1);
    first_grant = -1; strobe_at = -1; we_cnt = 0;
    while (n < 70) begin
      mstep(0, 0, 0, 1, 1);
      if (got.grant && first_grant == -1) first_grant = int'(cur_n);
      if (got.ms) strobe_at = int'(cur_n);
      we_cnt += int'(got.we);
    end
    chk("a_first_grant", first_grant, 56);
    chk("a_strobe_cycle", strobe_at, 59);
    chk("a_we_cycles", we_cnt, 2);
    chk("a_done_held", 32'(got.done), 1);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      mstep(0, 0, 0, 0, 1);
      done_cnt += int'(got.done);
    end
    chk("a_done_release_ok", 32'(done_cnt <= 3 && got.done == 1'b0), 1);

    // B: CPU halted, MCU borrows the CPU slot; no cpu_en in that frame.
    while (n < 80) mstep(0, 0, 1, 0, 0);
    first_grant = -1; strobe_at = -1; cen_seen = 0; gslot = 2'd3;
    while (n < 96) begin
      mstep(0, 0, 1, 1, 0);
      if (got.grant && first_grant == -1) begin
        first_grant = int'(cur_n);
        gslot = got.slot;
      end
      if (got.ms) strobe_at = int'(cur_n);
      cen_seen += int'(got.cen);
    end
    chk("b_first_grant", first_grant, 88);
    chk("b_grant_slot", 32'(gslot), 1);
    chk("b_strobe_cycle", strobe_at, 91);
    chk("b_cpu_en_count", cen_seen, 0);
    chk("b_done_held", 32'(got.done), 1);

    // C: pending dropped at cnt 1 of the active slot aborts the access.
    while (n < 100) mstep(0, 0, 0, 0, 1);
    while (n < 105) mstep(0, 0, 0, 1, 1);
    chk("c_grant_start", 32'(got.grant), 1);
    ms_seen = 0; done_seen = 0;
    while (n < 112) begin
      mstep(0, 0, 0, 0, 1);
      if (cur_n == 107) begin
        chk("c_grant_abort", 32'(got.grant), 0);
        chk("c_we_abort", 32'(got.we), 0);
      end
      ms_seen += int'(got.ms);
      done_seen += int'(got.done);
    end
    chk("c_no_strobe", ms_seen, 0);
    chk("c_no_done", done_seen, 0);

    // D: reset pulsed at cnt 2 of an MCU write.
    while (n < 118) mstep(0, 0, 0, 1, 1);
    chk("d_we_before", 32'(got.we), 1);
    mstep(1, 0, 0, 1, 1);
    chk("d_we_in_reset", 32'(got.we), 0);
    chk("d_done_in_reset", 32'(got.done), 0);
    mstep(0, 0, 0, 0, 0);
    chk("d_slot_after", 32'(got.slot), 0);
    chk("d_grant_after", 32'(got.grant), 0);
    chk("d_we_after", 32'(got.we), 0);

    // Randomized run against the model.
    h = 1'b0; p = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 5) == 0) h = !h;
      if ($urandom_range(0, 9) == 0) p = !p;
      mstep(r, 1'($urandom), h, p, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
